// File: rtl/imem_prefetch_buf.sv
// Instruction prefetch buffer: streams sequential words from the instruction bus
// into a small FIFO ahead of the core and restarts the stream on any non-sequential fetch.
module imem_prefetch_buf #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [ADDR_WIDTH-1:0] s_addr_i,
    output logic [31:0]           s_rdata_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [31:0]           m_wdata_o,
    output logic [3:0]            m_we_o,
    input  logic [31:0]           m_rdata_i
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned WADDR_W = ADDR_WIDTH - 2;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  data;
    } entry_t;

    state_t                  state_q, state_d;
    entry_t                  fifo_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   fetch_pc_q;
    logic [ADDR_WIDTH-1:0]   stale_addr_q;
    logic                    stream_ok_q;
    logic                    discard_q;
    logic [CNT_W-1:0]        count_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W-1:0]        wr_ptr_q;

    logic [ADDR_WIDTH-1:0]   aligned_addr;
    entry_t                  head;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    hit;
    logic                    in_flight_match;
    logic                    miss;
    logic                    push;
    logic                    pop;

    assign m_wdata_o = '0;
    assign m_we_o    = '0;

    // Request classification against the expected next address
    always_comb begin
        aligned_addr    = s_addr_i & ~ADDR_WIDTH'(3);
        head            = fifo_q[rd_ptr_q];
        fifo_empty      = (count_q == '0);
        fifo_full       = (count_q == CNT_W'(DEPTH));
        hit             = s_valid_i && !fifo_empty && stream_ok_q &&
                          (aligned_addr[ADDR_WIDTH-1:2] == head.waddr);
        in_flight_match = s_valid_i && fifo_empty && stream_ok_q &&
                          (aligned_addr == fetch_pc_q);
        miss            = s_valid_i && !hit && !in_flight_match;
        pop             = hit;
        push            = (state_q == FETCH) && m_valid_o && m_ready_i && !miss;
    end

    always_comb begin
        s_ready_o = hit;
        s_rdata_o = hit ? head.data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A miss while a request is still unanswered must wait for that stale response
    always_comb begin
        state_d = state_q;
        if (miss) begin
            state_d = (m_valid_o && !m_ready_i) ? DRAIN : FETCH;
        end else if ((state_q == DRAIN) && m_ready_i) begin
            state_d = FETCH;
        end
    end

    always_comb begin
        m_valid_o = ((state_q == FETCH) && !fifo_full) || (state_q == DRAIN);
        m_addr_o  = discard_q ? stale_addr_q : fetch_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= '0;
            stale_addr_q <= '0;
            stream_ok_q  <= 1'b0;
            discard_q    <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else if (miss) begin
            fetch_pc_q   <= aligned_addr;
            stale_addr_q <= m_addr_o;
            stream_ok_q  <= 1'b1;
            discard_q    <= m_valid_o && !m_ready_i;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            if (push) begin
                fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
                wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if ((state_q == DRAIN) && m_ready_i) begin
                discard_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {m_addr_o[ADDR_WIDTH-1:2], m_rdata_i};
        end
    end

endmodule

// File: tb/tb_imem_prefetch_buf.sv
// Directed bench for imem_prefetch_buf with a registered memory of programmable latency.
module tb_imem_prefetch_buf;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_we;
    logic [31:0] m_rdata;

    int unsigned lat;
    int unsigned wait_cnt;
    int          checks;
    int          errors;

    imem_prefetch_buf #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_addr_i  (s_addr),
        .s_rdata_o (s_rdata),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_addr_o  (m_addr),
        .m_wdata_o (m_wdata),
        .m_we_o    (m_we),
        .m_rdata_i (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h0F0F_0000;
    endfunction

    // Memory answers lat+1 cycles after it first sees a request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready  <= 1'b0;
            wait_cnt <= 0;
        end else if (m_ready) begin
            m_ready  <= 1'b0;
            wait_cnt <= 0;
        end else if (m_valid) begin
            if (wait_cnt >= lat) m_ready <= 1'b1;
            else wait_cnt <= wait_cnt + 1;
        end
    end

    always_comb m_rdata = m_ready ? mem_word(m_addr) : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] a, input logic [31:0] word_addr);
        s_valid = 1'b1;
        s_addr  = a;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_data"}, s_rdata, mem_word(word_addr));
        step();
    endtask

    task automatic count_responses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (m_ready) n++;
            step();
        end
    endtask

    initial begin
        int          n;
        int          k;
        logic [31:0] got [3];

        checks  = 0;
        errors  = 0;
        s_valid = 1'b0;
        s_addr  = 32'h0;
        lat     = 0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_s_rdata", s_rdata, 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        step();
        rst_n = 1'b1;

        // Cold start at 0x0
        s_valid = 1'b1;
        s_addr  = 32'h0;
        @(negedge clk);
        chk("cold_c0_mvalid", 32'(m_valid), 32'd0);
        chk("cold_c0_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("cold_c1_mvalid", 32'(m_valid), 32'd1);
        chk("cold_c1_maddr", m_addr, 32'h0);
        chk("cold_c1_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("cold_c2_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("cold_c3_sready", 32'(s_ready), 32'd1);
        chk("cold_c3_data", s_rdata, mem_word(32'h0));
        step();
        s_valid = 1'b0;

        // Core stalls: exactly 0x4..0x10 are fetched, then the bus goes quiet
        count_responses(14, n);
        @(negedge clk);
        chk("fill_resp", 32'(n), 32'd4);
        chk("fill_mvalid", 32'(m_valid), 32'd0);
        chk("fill_maddr", m_addr, 32'h14);
        step();

        // Jump while full: old entries must never be returned
        s_valid = 1'b1;
        s_addr  = 32'h100;
        @(negedge clk);
        chk("jmp_j0_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("jmp_j1_mvalid", 32'(m_valid), 32'd1);
        chk("jmp_j1_maddr", m_addr, 32'h100);
        chk("jmp_j1_sready", 32'(s_ready), 32'd0);
        chk("jmp_j1_count", 32'(dut.count_q), 32'd0);
        step();
        @(negedge clk);
        chk("jmp_j2_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("jmp_j3_sready", 32'(s_ready), 32'd1);
        chk("jmp_j3_data", s_rdata, mem_word(32'h100));
        step();
        s_valid = 1'b0;
        count_responses(14, n);
        chk("refill_resp", 32'(n), 32'd4);

        // Pop of 0x108 coincides with push of 0x114
        expect_hit("hit104", 32'h104, 32'h104);
        s_valid = 1'b0;
        @(negedge clk);
        chk("pp_p1_mvalid", 32'(m_valid), 32'd1);
        chk("pp_p1_maddr", m_addr, 32'h114);
        step();
        chk("pp_p2_mready", 32'(m_ready), 32'd1);
        expect_hit("hit108", 32'h108, 32'h108);
        chk("pp_count", 32'(dut.count_q), 32'd3);
        chk("pp_maddr", m_addr, 32'h118);
        expect_hit("hit10c", 32'h10C, 32'h10C);
        expect_hit("hit110", 32'h110, 32'h110);
        expect_hit("hit114", 32'h114, 32'h114);
        s_valid = 1'b0;
        count_responses(14, n);
        @(negedge clk);
        chk("fill2_resp", 32'(n), 32'd3);
        chk("fill2_mvalid", 32'(m_valid), 32'd0);
        chk("fill2_maddr", m_addr, 32'h128);
        step();

        // Jump while 0x128 is outstanding on a slow memory, then jump again in DRAIN
        lat = 5;
        expect_hit("hit118", 32'h118, 32'h118);
        s_valid = 1'b0;
        @(negedge clk);
        chk("dr_q1_mvalid", 32'(m_valid), 32'd1);
        chk("dr_q1_maddr", m_addr, 32'h128);
        step();
        s_valid = 1'b1;
        s_addr  = 32'h300;
        @(negedge clk);
        chk("dr_q2_sready", 32'(s_ready), 32'd0);
        step();
        s_addr = 32'h200;
        @(negedge clk);
        chk("dr_q3_mvalid", 32'(m_valid), 32'd1);
        chk("dr_q3_maddr", m_addr, 32'h128);
        chk("dr_q3_sready", 32'(s_ready), 32'd0);
        step();
        n = 0;
        while (!m_ready && n < 20) begin
            @(negedge clk);
            chk("dr_hold_mvalid", 32'(m_valid), 32'd1);
            chk("dr_hold_maddr", m_addr, 32'h128);
            chk("dr_hold_sready", 32'(s_ready), 32'd0);
            step();
            n++;
        end
        chk("dr_len", 32'(n), 32'd3);
        lat = 0;
        @(negedge clk);
        chk("dr_resp_maddr", m_addr, 32'h128);
        chk("dr_resp_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("dr_after_mvalid", 32'(m_valid), 32'd1);
        chk("dr_after_maddr", m_addr, 32'h200);
        chk("dr_after_count", 32'(dut.count_q), 32'd0);
        step();
        @(negedge clk);
        chk("dr_q9_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("dr_q10_sready", 32'(s_ready), 32'd1);
        chk("dr_q10_data", s_rdata, mem_word(32'h200));
        step();
        s_valid = 1'b0;

        // Miss in the same cycle as a response: data dropped, no DRAIN
        chk("sim_mready", 32'(m_ready), 32'd1);
        s_valid = 1'b1;
        s_addr  = 32'h400;
        @(negedge clk);
        chk("sim_s0_maddr", m_addr, 32'h204);
        chk("sim_s0_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("sim_s1_mvalid", 32'(m_valid), 32'd1);
        chk("sim_s1_maddr", m_addr, 32'h400);
        chk("sim_s1_count", 32'(dut.count_q), 32'd0);
        step();
        @(negedge clk);
        chk("sim_s2_sready", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("sim_s3_sready", 32'(s_ready), 32'd1);
        chk("sim_s3_data", s_rdata, mem_word(32'h400));
        step();

        // Address wrap-around at the top of memory
        s_addr = 32'hFFFF_FFF8;
        step();
        s_valid = 1'b0;
        k = 0;
        for (int i = 0; i < 30 && k < 3; i++) begin
            if (m_ready) begin
                got[k] = m_addr;
                k++;
            end
            step();
        end
        chk("wrap_resp", 32'(k), 32'd3);
        chk("wrap_addr0", got[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", got[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", got[2], 32'h0000_0000);
        expect_hit("hit_unaligned", 32'hFFFF_FFFA, 32'hFFFF_FFF8);

        // Unaligned jump target is fetched as its word address
        s_addr = 32'h102;
        @(negedge clk);
        chk("al_sready0", 32'(s_ready), 32'd0);
        step();
        @(negedge clk);
        chk("al_mvalid", 32'(m_valid), 32'd1);
        chk("al_maddr", m_addr, 32'h100);
        n = 0;
        while (!s_ready && n < 10) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("al_wait", 32'(n), 32'd2);
        chk("al_data", s_rdata, mem_word(32'h100));
        step();
        s_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
